// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Shares the single register-file write port between the pipeline
//   writeback stage (A) and a long-latency unit (B). B results wait in a
//   2-entry FIFO. A normally wins. A starvation counter forces a one-cycle
//   stall so that B can drain. A 32-bit pending scoreboard marks registers
//   that still await a B result, so decode can detect RAW hazards.
//
// Ports
//   Clk, reset              clock; synchronous active-high reset
//   wbWrite/wbReg/wbData    writer A request
//   luValid/luReg/luData    writer B offer; accepted when luReady is high
//   luReady                 FIFO can accept a B result this cycle
//   issueValid/issueReg     B operation issued; marks issueReg pending
//   queryReg1/2, busy1/2    scoreboard lookups for decode
//   stall                   pipeline must hold; A's request is ignored
//   regWrite/writeReg/writeData  registered register-file write port
module regfile_write_arbiter #(
    parameter int MAX_WAIT = 4,
    parameter int CNT_W    = 4
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic        wbWrite,
    input  logic [4:0]  wbReg,
    input  logic [31:0] wbData,
    input  logic        luValid,
    input  logic [4:0]  luReg,
    input  logic [31:0] luData,
    output logic        luReady,
    input  logic        issueValid,
    input  logic [4:0]  issueReg,
    input  logic [4:0]  queryReg1,
    input  logic [4:0]  queryReg2,
    output logic        busy1,
    output logic        busy2,
    output logic        stall,
    output logic        regWrite,
    output logic [4:0]  writeReg,
    output logic [31:0] writeData
);

    logic [4:0]       fifo_reg  [2];
    logic [31:0]      fifo_data [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic [CNT_W-1:0] wait_cnt;
    logic [31:0]      pending;
    logic [31:0]      pending_next;

    logic             a_req;
    logic             fifo_nonempty;
    logic             grant_a;
    logic             grant_b;
    logic             push;
    logic             pop;
    logic [4:0]       head_reg;
    logic [31:0]      head_data;

    assign fifo_nonempty = (count != 2'd0);
    assign head_reg      = fifo_reg[rd_ptr];
    assign head_data     = fifo_data[rd_ptr];

    // A write to r0 is not a real request: it neither wins nor blocks B.
    assign a_req   = wbWrite && (wbReg != 5'd0);

    // Readiness ignores a same-cycle pop, so a full FIFO never accepts.
    assign luReady = !reset && (count != 2'd2);
    assign stall   = !reset && (wait_cnt == CNT_W'(MAX_WAIT)) && fifo_nonempty;

    assign push    = luValid && luReady;
    assign pop     = grant_b && !reset;

    assign busy1   = (queryReg1 != 5'd0) && pending[queryReg1];
    assign busy2   = (queryReg2 != 5'd0) && pending[queryReg2];

    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (stall)
            grant_b = 1'b1;
        else if (a_req)
            grant_a = 1'b1;
        else if (fifo_nonempty)
            grant_b = 1'b1;
    end

    // Set is applied after clear so a same-cycle issue keeps the bit.
    always_comb begin
        pending_next = pending;
        if (grant_b && (head_reg != 5'd0))
            pending_next[head_reg] = 1'b0;
        if (issueValid && (issueReg != 5'd0))
            pending_next[issueReg] = 1'b1;
    end

    // Payload storage needs no reset; push is held low during reset.
    always_ff @(posedge Clk) begin
        if (push) begin
            fifo_reg[wr_ptr]  <= luReg;
            fifo_data[wr_ptr] <= luData;
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            count     <= 2'd0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            wait_cnt  <= '0;
            pending   <= '0;
            regWrite  <= 1'b0;
            writeReg  <= '0;
            writeData <= '0;
        end else begin
            if (push)
                wr_ptr <= ~wr_ptr;
            if (pop)
                rd_ptr <= ~rd_ptr;

            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase

            if (!fifo_nonempty || grant_b)
                wait_cnt <= '0;
            else if (grant_a && (wait_cnt != CNT_W'(MAX_WAIT)))
                wait_cnt <= wait_cnt + CNT_W'(1);

            // A popped r0 entry is discarded: no write, data/reg held.
            regWrite <= grant_a || (grant_b && (head_reg != 5'd0));
            if (grant_a) begin
                writeReg  <= wbReg;
                writeData <= wbData;
            end else if (grant_b && (head_reg != 5'd0)) begin
                writeReg  <= head_reg;
                writeData <= head_data;
            end

            pending <= pending_next;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
module tb_regfile_write_arbiter;

    localparam int MAX_WAIT = 4;

    logic        Clk = 1'b0;
    logic        reset, wbWrite, luValid, issueValid;
    logic [4:0]  wbReg, luReg, issueReg, queryReg1, queryReg2;
    logic [31:0] wbData, luData;
    logic        luReady, busy1, busy2, stall, regWrite;
    logic [4:0]  writeReg;
    logic [31:0] writeData;

    always #5 Clk = ~Clk;

    regfile_write_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(4)) dut (
        .Clk(Clk), .reset(reset),
        .wbWrite(wbWrite), .wbReg(wbReg), .wbData(wbData),
        .luValid(luValid), .luReg(luReg), .luData(luData), .luReady(luReady),
        .issueValid(issueValid), .issueReg(issueReg),
        .queryReg1(queryReg1), .queryReg2(queryReg2),
        .busy1(busy1), .busy2(busy2), .stall(stall),
        .regWrite(regWrite), .writeReg(writeReg), .writeData(writeData)
    );

    typedef struct {
        logic        rst;
        logic        wbw;
        logic [4:0]  wbr;
        logic [31:0] wbd;
        logic        luv;
        logic [4:0]  lur;
        logic [31:0] lud;
        logic        iv;
        logic [4:0]  ir;
        logic [4:0]  q1;
        logic [4:0]  q2;
        logic        e_ready;
        logic        e_stall;
        logic        e_busy1;
        logic        e_rw;
        logic [4:0]  e_wreg;
        logic [31:0] e_wdata;
    } vec_t;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
    } ent_t;

    int errors = 0;
    int checks = 0;

    // Reference model: queue FIFO, integer wait count, bit-vector scoreboard.
    ent_t        mq[$];
    int          m_wc = 0;
    bit [31:0]   m_pend = '0;
    logic        m_rw = 1'b0;
    logic [4:0]  m_wr = '0;
    logic [31:0] m_wd = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic rst, input logic wbw, input logic [4:0] wbr,
                                input logic [31:0] wbd, input logic luv, input logic [4:0] lur,
                                input logic [31:0] lud, input logic iv, input logic [4:0] ir,
                                input logic [4:0] q1, input logic e_ready, input logic e_stall,
                                input logic e_busy1, input logic e_rw, input logic [4:0] e_wreg,
                                input logic [31:0] e_wdata);
        vec_t v;
        v.rst = rst; v.wbw = wbw; v.wbr = wbr; v.wbd = wbd;
        v.luv = luv; v.lur = lur; v.lud = lud; v.iv = iv; v.ir = ir;
        v.q1 = q1; v.q2 = 5'd0;
        v.e_ready = e_ready; v.e_stall = e_stall; v.e_busy1 = e_busy1;
        v.e_rw = e_rw; v.e_wreg = e_wreg; v.e_wdata = e_wdata;
        return v;
    endfunction

    function automatic vec_t idle();
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    // Advance the model by one clock using the rules of the arbiter.
    task automatic model_update(input vec_t v, input bit ready_now);
        bit   a_ok, has_b;
        ent_t e;
        if (v.rst) begin
            mq.delete();
            m_wc = 0; m_pend = '0;
            m_rw = 1'b0; m_wr = '0; m_wd = '0;
        end else begin
            a_ok  = v.wbw && (v.wbr != 0);
            has_b = (mq.size() != 0);
            if ((has_b && m_wc == MAX_WAIT) || (!a_ok && has_b)) begin
                e = mq.pop_front();
                m_rw = (e.r != 0);
                if (e.r != 0) begin
                    m_wr = e.r; m_wd = e.d; m_pend[e.r] = 1'b0;
                end
                m_wc = 0;
            end else if (a_ok) begin
                m_rw = 1'b1; m_wr = v.wbr; m_wd = v.wbd;
                m_wc = has_b ? ((m_wc < MAX_WAIT) ? m_wc + 1 : m_wc) : 0;
            end else begin
                m_rw = 1'b0;
                m_wc = 0;
            end
            if (v.luv && ready_now) begin
                e.r = v.lur; e.d = v.lud;
                mq.push_back(e);
            end
            if (v.iv && v.ir != 0)
                m_pend[v.ir] = 1'b1;
        end
    endtask

    task automatic step(input vec_t v, input bit use_tab, input string tag);
        bit m_ready, m_stall, m_busy1, m_busy2;
        @(negedge Clk);
        reset = v.rst; wbWrite = v.wbw; wbReg = v.wbr; wbData = v.wbd;
        luValid = v.luv; luReg = v.lur; luData = v.lud;
        issueValid = v.iv; issueReg = v.ir; queryReg1 = v.q1; queryReg2 = v.q2;
        #1;
        m_ready = !v.rst && (mq.size() != 2);
        m_stall = !v.rst && (m_wc == MAX_WAIT) && (mq.size() != 0);
        m_busy1 = (v.q1 != 0) && m_pend[v.q1];
        m_busy2 = (v.q2 != 0) && m_pend[v.q2];
        chk({tag, "_luReady"}, luReady, m_ready);
        chk({tag, "_stall"}, stall, m_stall);
        chk({tag, "_busy1"}, busy1, m_busy1);
        chk({tag, "_busy2"}, busy2, m_busy2);
        if (use_tab) begin
            chk({tag, "_tab_luReady"}, luReady, v.e_ready);
            chk({tag, "_tab_stall"}, stall, v.e_stall);
            chk({tag, "_tab_busy1"}, busy1, v.e_busy1);
        end
        model_update(v, m_ready);
        @(posedge Clk);
        #1;
        chk({tag, "_regWrite"}, regWrite, m_rw);
        chk({tag, "_writeReg"}, writeReg, m_wr);
        chk({tag, "_writeData"}, writeData, m_wd);
        if (use_tab) begin
            chk({tag, "_tab_regWrite"}, regWrite, v.e_rw);
            chk({tag, "_tab_writeReg"}, writeReg, v.e_wreg);
            chk({tag, "_tab_writeData"}, writeData, v.e_wdata);
        end
    endtask

    initial begin
        vec_t tab[13];
        vec_t v;

        //            rst wbw wbr wbd       luv lur lud    iv ir q1  rdy stl b1  rw wreg wdata
        tab[0]  = mk(1, 0, 0, 0,          0, 0, 0,     0, 0, 0,  0, 0, 0,  0, 0, 0);
        tab[1]  = mk(0, 0, 0, 0,          0, 0, 0,     0, 0, 5,  1, 0, 0,  0, 0, 0);
        tab[2]  = mk(0, 1, 8, 32'h1234,   0, 0, 0,     0, 0, 5,  1, 0, 0,  1, 8, 32'h1234);
        tab[3]  = mk(0, 0, 0, 0,          0, 0, 0,     0, 0, 5,  1, 0, 0,  0, 8, 32'h1234);
        tab[4]  = mk(0, 0, 0, 0,          0, 0, 0,     1, 5, 5,  1, 0, 0,  0, 8, 32'h1234);
        tab[5]  = mk(0, 1, 9, 32'h99,     1, 5, 32'hAA, 0, 0, 5, 1, 0, 1,  1, 9, 32'h99);
        tab[6]  = mk(0, 1, 9, 32'h99,     0, 0, 0,     0, 0, 5,  1, 0, 1,  1, 9, 32'h99);
        tab[7]  = mk(0, 1, 9, 32'h99,     0, 0, 0,     0, 0, 5,  1, 0, 1,  1, 9, 32'h99);
        tab[8]  = mk(0, 1, 9, 32'h99,     0, 0, 0,     0, 0, 5,  1, 0, 1,  1, 9, 32'h99);
        tab[9]  = mk(0, 1, 9, 32'h99,     0, 0, 0,     0, 0, 5,  1, 0, 1,  1, 9, 32'h99);
        tab[10] = mk(0, 1, 9, 32'h99,     0, 0, 0,     0, 0, 5,  1, 1, 1,  1, 5, 32'hAA);
        tab[11] = mk(0, 1, 9, 32'h99,     0, 0, 0,     0, 0, 5,  1, 0, 0,  1, 9, 32'h99);
        tab[12] = mk(0, 0, 0, 0,          0, 0, 0,     0, 0, 5,  1, 0, 0,  0, 9, 32'h99);

        for (int i = 0; i < 13; i++)
            step(tab[i], 1'b1, $sformatf("row%0d", i));

        // FIFO full: two entries land while A keeps winning.
        v = idle(); v.wbw = 1; v.wbr = 10; v.wbd = 32'h10;
        v.luv = 1; v.lur = 3; v.lud = 32'h33; step(v, 0, "full_push3");
        v.lur = 4; v.lud = 32'h44;            step(v, 0, "full_push4");
        v.lur = 11; v.lud = 32'hBB;           step(v, 0, "full_reject");
        chk("full_luReady_low", luReady, 1'b0);
        v.wbw = 0;                            step(v, 0, "full_pop3");
        chk("full_order_first", writeReg, 5'd3);
        step(v, 0, "full_pop4");
        chk("full_order_second", writeReg, 5'd4);
        v = idle();                           step(v, 0, "full_pop11");
        chk("full_late_push", writeReg, 5'd11);

        // r0 handling on both writers.
        v = idle(); v.luv = 1; v.lur = 6; v.lud = 32'h66; step(v, 0, "r0_push6");
        v = idle(); v.wbw = 1; v.wbr = 0; v.wbd = 32'hDEAD; step(v, 0, "r0_a_yields");
        chk("r0_b_granted", writeReg, 5'd6);
        chk("r0_b_regWrite", regWrite, 1'b1);
        v = idle(); v.luv = 1; v.lur = 0; v.lud = 32'h77; step(v, 0, "r0_push0");
        v = idle();                                       step(v, 0, "r0_pop0");
        chk("r0_pop_no_write", regWrite, 1'b0);

        // Set/clear collision on reg 7.
        v = idle(); v.iv = 1; v.ir = 7; v.q1 = 7;          step(v, 0, "col_issue");
        v = idle(); v.luv = 1; v.lur = 7; v.lud = 32'h70; v.q1 = 7; step(v, 0, "col_push");
        v = idle(); v.iv = 1; v.ir = 7; v.q1 = 7;          step(v, 0, "col_both");
        chk("col_writeReg", writeReg, 5'd7);
        chk("col_pending_kept", busy1, 1'b1);

        // Reset with two entries buffered.
        v = idle(); v.wbw = 1; v.wbr = 13; v.wbd = 32'hD;
        v.luv = 1; v.lur = 12; v.lud = 32'hC;  step(v, 0, "rst_push12");
        v.lur = 14; v.lud = 32'hE;             step(v, 0, "rst_push14");
        v = idle(); v.rst = 1;                 step(v, 0, "rst_assert");
        for (int i = 0; i < 3; i++) begin
            v = idle();
            step(v, 0, $sformatf("rst_after%0d", i));
            chk($sformatf("rst_no_write%0d", i), regWrite, 1'b0);
        end

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            v = idle();
            v.rst = ($urandom_range(0, 99) == 0);
            v.wbw = ($urandom_range(0, 3) != 0);
            v.wbr = 5'($urandom_range(0, 7));
            v.wbd = $urandom;
            v.luv = 1'($urandom_range(0, 1));
            v.lur = 5'($urandom_range(0, 7));
            v.lud = $urandom;
            v.iv  = ($urandom_range(0, 3) == 0);
            v.ir  = 5'($urandom_range(0, 7));
            v.q1  = 5'($urandom_range(0, 7));
            v.q2  = 5'($urandom_range(0, 7));
            step(v, 0, $sformatf("rnd%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the single register-file write port (regWrite/writeReg/writeData, written on negedge Clk) between two writers:
  - the pipeline writeback stage (A);
  - a long-latency unit such as mult/div/load-miss (B).
- B results are buffered in a 2-entry FIFO. A has priority, and a starvation counter forces a one-cycle pipeline stall so B drains.
- A 32-bit pending scoreboard tracks registers awaiting B results, so decode can detect RAW hazards.

Parameters:
- MAX_WAIT, 4: cycles a non-empty B FIFO head may be denied before stall is forced; legal 1..15.
- CNT_W, 4: width of the wait counter; must hold MAX_WAIT.

Ports:
- Clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- wbWrite  input  1  A requests a write this cycle.
- wbReg  input  5  A destination register.
- wbData  input  32  A write data.
- luValid  input  1  B offers a result.
- luReg  input  5  B destination register.
- luData  input  32  B result data.
- luReady  output  1  FIFO can accept; push when luValid && luReady.
- issueValid  input  1  a B operation is issued; marks issueReg pending.
- issueReg  input  5  destination of the issued B operation.
- queryReg1  input  5  decode source register 1.
- queryReg2  input  5  decode source register 2.
- busy1  output  1  pending[queryReg1].
- busy2  output  1  pending[queryReg2].
- stall  output  1  pipeline must hold this cycle; A's request is ignored and must be re-presented.
- regWrite  output  1  to register file.
- writeReg  output  5  to register file.
- writeData  output  32  to register file.

Behaviour:
- Reset (reset high at posedge):
  - FIFO emptied (count=0, pointers=0), waitCnt=0, pending=0.
  - regWrite=0, writeReg=0, writeData=0.
  - While reset is high: luReady=0, stall=0, and pushes/issues are ignored.
  - Reset mid-transfer discards buffered B results without writing them.
- luReady = !reset && (count != 2), combinational. When full, no push is accepted even if a pop occurs in the same cycle.
- stall = (waitCnt == MAX_WAIT) && count != 0, combinational from registered state.
- Grant, evaluated combinationally each cycle:
  - if stall, grant B head;
  - else if wbWrite && wbReg != 0, grant A;
  - else if count != 0, grant B head;
  - else no grant.
- wbWrite with wbReg == 0 never wins and never blocks B.
- Outputs registered, latency 1 cycle:
  - On the posedge after a grant: regWrite=1, writeReg/writeData = granted request.
  - The register file then writes on the following negedge.
  - No grant gives regWrite=0; writeReg/writeData hold their previous values.
- B-granted entry is popped. If its reg is 0, it is popped with regWrite=0.
- Count update:
  - push and pop in the same cycle leave count unchanged;
  - FIFO order is strictly first-in-first-out;
  - pointers wrap modulo 2.
- waitCnt:
  - cleared when count==0 or when B is granted;
  - else incremented when A wins over a non-empty FIFO;
  - saturates at MAX_WAIT.
- Scoreboard:
  - issueValid && issueReg != 0 sets pending[issueReg];
  - a B grant clears pending[granted reg];
  - set and clear of the same reg in the same cycle: set wins;
  - A writes never touch pending.
- busy1/busy2 are combinational reads of pending; register 0 always reads 0.

Test Plan:
- Reset then idle: regWrite=0, writeReg=0, luReady=1, stall=0, busy1=busy2=0.
- A alone: wbWrite=1, wbReg=8, wbData=32'h1234 for one cycle; next cycle regWrite=1, writeReg=8, writeData=32'h1234; the following cycle regWrite=0.
- Priority and starvation (MAX_WAIT=4):
  - issue reg 5 (busy for queryReg1=5 reads 1), then push luReg=5, luData=32'hAA;
  - hold wbWrite=1 to reg 9 continuously;
  - A wins 4 cycles, stall=1 on the 5th, B written next cycle (writeReg=5, writeData=32'hAA), busy1 returns 0 and waitCnt clears.
- FIFO full: push regs 3 and 4 while A is busy; luReady=0, and a third luValid is not accepted until a pop. When A drops, order is reg 3 then reg 4.
- Register 0: A to reg 0 with the FIFO holding reg 6 grants B (writeReg=6). A B entry to reg 0 is popped with regWrite=0.
- Set/clear collision: issue reg 7 in the same cycle a pending reg-7 result is granted; pending[7] stays 1. Reset asserted with 2 entries buffered gives count=0 and no further regWrite.
